// File: rtl/decode_operand_stage.sv
// Decode/operand-read stage: resolves register operands through execute and write-back forwarding,
// presents them in a stall-holding valid/ready output register and keeps saturating perf counters.
module decode_operand_stage #(
    parameter int unsigned REG_W      = 64,
    parameter int unsigned REG_N      = 16,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned N_SRC      = 3,
    parameter int unsigned WB_N       = 2,
    parameter int unsigned PAYLOAD_W  = 128,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PAYLOAD_W-1:0]        in_payload,
    input  logic [N_SRC*REG_ADDR_W-1:0] in_addr,
    input  logic [N_SRC-1:0]            in_use,
    input  logic [REG_N*REG_W-1:0]      gpr_flat,
    input  logic                        exe_valid,
    input  logic                        exe_is_load,
    input  logic [REG_ADDR_W-1:0]       exe_addr,
    input  logic [REG_W-1:0]            exe_data,
    input  logic [WB_N-1:0]             wri_valid,
    input  logic [WB_N*REG_ADDR_W-1:0]  wri_addr,
    input  logic [WB_N*REG_W-1:0]       wri_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PAYLOAD_W-1:0]        out_payload,
    output logic [N_SRC*REG_ADDR_W-1:0] out_addr,
    output logic [N_SRC-1:0]            out_use,
    output logic [N_SRC*REG_W-1:0]      out_val,
    output logic [CNT_W-1:0]            hazard_cnt,
    output logic [CNT_W-1:0]            stall_cnt
);
    localparam int unsigned VAL_BUS_W = N_SRC * REG_W;

    logic [VAL_BUS_W-1:0] sel_val_c;
    logic [VAL_BUS_W-1:0] refresh_val_c;
    logic                 load_use_c;
    logic                 accept_c;
    logic                 held_c;

    // Architectural register read; addresses beyond REG_N read as zero
    function automatic logic [REG_W-1:0] gpr_read(input logic [REG_ADDR_W-1:0] addr);
        logic [REG_W-1:0] v;
        v = '0;
        for (int r = 0; r < int'(REG_N); r++) begin
            if (addr == REG_ADDR_W'(r)) v = gpr_flat[r*REG_W +: REG_W];
        end
        return v;
    endfunction

    // Write-back forwarding; scanning oldest first lets the youngest matching layer win
    function automatic logic [REG_W-1:0] wb_fwd(input logic [REG_ADDR_W-1:0] addr,
                                                 input logic [REG_W-1:0]      dflt);
        logic [REG_W-1:0] v;
        v = dflt;
        for (int j = int'(WB_N) - 1; j >= 0; j--) begin
            if (wri_valid[j] && wri_addr[j*REG_ADDR_W +: REG_ADDR_W] == addr)
                v = wri_data[j*REG_W +: REG_W];
        end
        return v;
    endfunction

    always_comb begin
        sel_val_c     = '0;
        refresh_val_c = out_val;
        load_use_c    = 1'b0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (in_use[i]) begin
                if (exe_valid && !exe_is_load && exe_addr == in_addr[i*REG_ADDR_W +: REG_ADDR_W])
                    sel_val_c[i*REG_W +: REG_W] = exe_data;
                else
                    sel_val_c[i*REG_W +: REG_W] =
                        wb_fwd(in_addr[i*REG_ADDR_W +: REG_ADDR_W],
                               gpr_read(in_addr[i*REG_ADDR_W +: REG_ADDR_W]));
                if (exe_valid && exe_is_load && exe_addr == in_addr[i*REG_ADDR_W +: REG_ADDR_W])
                    load_use_c = 1'b1;
            end
            // A held op keeps picking up write-backs to its sources
            if (out_use[i])
                refresh_val_c[i*REG_W +: REG_W] =
                    wb_fwd(out_addr[i*REG_ADDR_W +: REG_ADDR_W], out_val[i*REG_W +: REG_W]);
        end
        load_use_c = load_use_c & in_valid;
    end

    assign held_c   = out_valid & ~out_ready;
    assign in_ready = rstn & ~flush & ~load_use_c & (~out_valid | out_ready);
    assign accept_c = in_valid & in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            out_addr    <= '0;
            out_use     <= '0;
            out_val     <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            out_addr    <= '0;
            out_use     <= '0;
            out_val     <= '0;
        end else if (accept_c) begin
            out_valid   <= 1'b1;
            out_payload <= in_payload;
            out_addr    <= in_addr;
            out_use     <= in_use;
            out_val     <= sel_val_c;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end else if (held_c) begin
            out_val     <= refresh_val_c;
        end
    end

    // Saturating counters, cleared only by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hazard_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (load_use_c && hazard_cnt != '1) hazard_cnt <= hazard_cnt + CNT_W'(1);
            if (held_c && stall_cnt != '1)      stall_cnt  <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_decode_operand_stage.sv
// Scoreboard bench for decode_operand_stage: a spec-level model pushes expected ops on accept,
// a monitor compares whatever the DUT presents.
module tb_decode_operand_stage;
    localparam int unsigned RW   = 64;
    localparam int unsigned RN   = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned NS   = 3;
    localparam int unsigned WB   = 2;
    localparam int unsigned PW   = 128;
    localparam int unsigned CW   = 4;
    localparam int          MAXC = 15;

    logic              clk;
    logic              rstn;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PW-1:0]     in_payload;
    logic [NS*AW-1:0]  in_addr;
    logic [NS-1:0]     in_use;
    logic [RN*RW-1:0]  gpr_flat;
    logic              exe_valid;
    logic              exe_is_load;
    logic [AW-1:0]     exe_addr;
    logic [RW-1:0]     exe_data;
    logic [WB-1:0]     wri_valid;
    logic [WB*AW-1:0]  wri_addr;
    logic [WB*RW-1:0]  wri_data;
    logic              out_valid;
    logic              out_ready;
    logic [PW-1:0]     out_payload;
    logic [NS*AW-1:0]  out_addr;
    logic [NS-1:0]     out_use;
    logic [NS*RW-1:0]  out_val;
    logic [CW-1:0]     hazard_cnt;
    logic [CW-1:0]     stall_cnt;

    typedef struct packed {
        logic [PW-1:0]    pl;
        logic [NS*AW-1:0] addr;
        logic [NS-1:0]    uses;
        logic [NS*RW-1:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic m_valid;
    int   m_hz;
    int   m_st;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [PW-1:0] pl_keep;

    decode_operand_stage #(
        .REG_W(RW), .REG_N(RN), .REG_ADDR_W(AW), .N_SRC(NS),
        .WB_N(WB), .PAYLOAD_W(PW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_addr(in_addr), .in_use(in_use), .gpr_flat(gpr_flat),
        .exe_valid(exe_valid), .exe_is_load(exe_is_load), .exe_addr(exe_addr), .exe_data(exe_data),
        .wri_valid(wri_valid), .wri_addr(wri_addr), .wri_data(wri_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_addr(out_addr), .out_use(out_use), .out_val(out_val),
        .hazard_cnt(hazard_cnt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: value an operand address reads, following the forwarding priority rules
    function automatic logic [RW-1:0] ref_val(input logic [AW-1:0] a);
        if (exe_valid && !exe_is_load && exe_addr == a) return exe_data;
        for (int j = 0; j < int'(WB); j++)
            if (wri_valid[j] && wri_addr[j*AW +: AW] == a) return wri_data[j*RW +: RW];
        return gpr_flat[a*RW +: RW];
    endfunction

    function automatic logic f_lu();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NS); i++)
            if (in_use[i] && in_addr[i*AW +: AW] == exe_addr) hit = 1'b1;
        return in_valid && exe_valid && exe_is_load && hit;
    endfunction

    function automatic exp_t f_snap();
        exp_t e;
        e.pl   = in_payload;
        e.addr = in_addr;
        e.uses = in_use;
        e.val  = '0;
        for (int i = 0; i < int'(NS); i++)
            if (in_use[i]) e.val[i*RW +: RW] = ref_val(in_addr[i*AW +: AW]);
        return e;
    endfunction

    function automatic exp_t f_refresh(input exp_t e);
        exp_t r;
        bit   found;
        r = e;
        for (int i = 0; i < int'(NS); i++) begin
            found = 1'b0;
            for (int j = 0; j < int'(WB); j++) begin
                if (!found && e.uses[i] && wri_valid[j] && wri_addr[j*AW +: AW] == e.addr[i*AW +: AW]) begin
                    r.val[i*RW +: RW] = wri_data[j*RW +: RW];
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Behavioural model of the stage state
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            m_hz    <= 0;
            m_st    <= 0;
            sb.delete();
        end else begin
            if (f_lu() && m_hz < MAXC) m_hz <= m_hz + 1;
            if (m_valid && !out_ready && m_st < MAXC) m_st <= m_st + 1;
            if (flush) begin
                m_valid <= 1'b0;
                sb.delete();
            end else if (in_valid && !f_lu() && (!m_valid || out_ready)) begin
                sb.push_back(f_snap());
                m_valid <= 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end else if (m_valid && sb.size() != 0) begin
                sb.push_front(f_refresh(sb.pop_front()));
            end
        end
    end

    // Monitor: samples mid low phase, pops on handshake
    initial forever begin
        @(negedge clk);
        #3;
        if (rstn === 1'b1) begin
            chk("out_valid", 256'(out_valid), 256'(m_valid));
            chk("in_ready", 256'(in_ready), 256'(!flush && !f_lu() && (!m_valid || out_ready)));
            chk("hazard_cnt", 256'(hazard_cnt), 256'(m_hz));
            chk("stall_cnt", 256'(stall_cnt), 256'(m_st));
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 256'(1), 256'(0));
                end else begin
                    mon_e = sb[0];
                    chk("out_payload", 256'(out_payload), 256'(mon_e.pl));
                    chk("out_addr", 256'(out_addr), 256'(mon_e.addr));
                    chk("out_use", 256'(out_use), 256'(mon_e.uses));
                    chk("out_val", 256'(out_val), 256'(mon_e.val));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle();
        in_valid    = 1'b0;
        flush       = 1'b0;
        exe_valid   = 1'b0;
        exe_is_load = 1'b0;
        wri_valid   = '0;
        out_ready   = 1'b1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        in_addr[i*AW +: AW] = a;
    endtask

    task automatic set_gpr(input int r, input logic [RW-1:0] v);
        gpr_flat[r*RW +: RW] = v;
    endtask

    task automatic set_wri(input int j, input logic [AW-1:0] a, input logic [RW-1:0] d);
        wri_addr[j*AW +: AW] = a;
        wri_data[j*RW +: RW] = d;
    endtask

    // Asynchronous reset mid-cycle with the queue head valid: everything must clear at once
    task automatic do_reset();
        @(negedge clk);
        #1;
        rstn = 1'b0;
        idle();
        in_valid = 1'b1;
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_val", 256'(out_val), 256'(0));
        chk("rst_payload", 256'(out_payload), 256'(0));
        chk("rst_counters", 256'({hazard_cnt, stall_cnt}), 256'(0));
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b1;
    endtask

    // Issue one op with current inputs, then check operand slot s on the following cycle
    task automatic issue_chk(input string nm, input int s, input logic [RW-1:0] exp);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk({nm, "_valid"}, 256'(out_valid), 256'(1));
        chk(nm, 256'(out_val[s*RW +: RW]), 256'(exp));
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        in_payload = '0;
        in_addr    = '0;
        in_use     = '0;
        exe_addr   = '0;
        exe_data   = '0;
        wri_addr   = '0;
        wri_data   = '0;
        for (int r = 0; r < int'(RN); r++) set_gpr(r, {$urandom(), $urandom()});
        repeat (2) @(negedge clk);
        do_reset();

        // Single op from reset
        @(negedge clk);
        set_gpr(3, 64'h11);
        set_addr(0, 4'd3);
        in_use = 3'b001;
        in_payload = {4{$urandom()}};
        #2 chk("s1_in_ready", 256'(in_ready), 256'(1));
        issue_chk("s1_val0", 0, 64'h11);
        chk("s1_in_ready_after", 256'(in_ready), 256'(1));

        // Forwarding priority: exe, then wri0, then wri1
        @(negedge clk);
        set_addr(0, 4'd5);
        in_use = 3'b001;
        exe_valid = 1'b1; exe_is_load = 1'b0; exe_addr = 4'd5; exe_data = 64'hAA;
        wri_valid = 2'b11; set_wri(0, 4'd5, 64'hBB); set_wri(1, 4'd5, 64'hCC);
        issue_chk("fwd_exe", 0, 64'hAA);
        @(negedge clk);
        exe_valid = 1'b0;
        issue_chk("fwd_wri0", 0, 64'hBB);
        @(negedge clk);
        wri_valid = 2'b10;
        issue_chk("fwd_wri1", 0, 64'hCC);

        // Load-use hazard blocks accept for two cycles, then forwards
        do_reset();
        @(negedge clk);
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_addr = 4'd7; exe_data = 64'h77;
        set_addr(1, 4'd7);
        in_use = 3'b010;
        in_valid = 1'b1;
        #2 chk("lu_ready0", 256'(in_ready), 256'(0));
        @(negedge clk);
        #2 chk("lu_ready1", 256'(in_ready), 256'(0));
        chk("lu_bubble", 256'(out_valid), 256'(0));
        @(negedge clk);
        exe_is_load = 1'b0;
        #2 chk("lu_hazard_cnt", 256'(hazard_cnt), 256'(2));
        chk("lu_ready_clear", 256'(in_ready), 256'(1));
        issue_chk("lu_fwd_val", 1, 64'h77);

        // Backpressure: held op picks up a write-back, payload holds
        do_reset();
        @(negedge clk);
        set_addr(0, 4'd4);
        in_use = 3'b001;
        set_gpr(4, 64'h44);
        pl_keep = {4{$urandom()}};
        in_payload = pl_keep;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_payload = ~pl_keep;
        @(negedge clk);
        wri_valid = 2'b01;
        set_wri(0, 4'd4, 64'h55);
        @(negedge clk);
        wri_valid = 2'b00;
        @(negedge clk);
        out_ready = 1'b1;
        #2 chk("bp_val0", 256'(out_val[RW-1:0]), 256'(64'h55));
        chk("bp_stall_cnt", 256'(stall_cnt), 256'(3));
        chk("bp_payload", 256'(out_payload), 256'(pl_keep));
        chk("bp_valid", 256'(out_valid), 256'(1));

        // Flush with in_valid and a held op
        do_reset();
        @(negedge clk);
        set_addr(0, 4'd2);
        in_use = 3'b001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        #2 chk("fl_in_ready", 256'(in_ready), 256'(0));
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #2 chk("fl_out_valid", 256'(out_valid), 256'(0));
        chk("fl_payload", 256'(out_payload), 256'(0));
        chk("fl_stall_cnt", 256'(stall_cnt), 256'(2));
        chk("fl_hazard_cnt", 256'(hazard_cnt), 256'(0));
        out_ready = 1'b1;

        // Saturation after 20+ stall cycles, then reset while still stalled
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (20) @(negedge clk);
        #2 chk("sat_stall_cnt", 256'(stall_cnt), 256'(15));
        chk("sat_held", 256'(out_valid), 256'(1));
        do_reset();
        #2 chk("rst_no_consume", 256'(out_valid), 256'(0));

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            @(negedge clk);
            if (c % 16 == 0)
                for (int r = 0; r < int'(RN); r++) set_gpr(r, {$urandom(), $urandom()});
            for (int i = 0; i < int'(NS); i++) set_addr(i, AW'($urandom_range(0, 7)));
            in_use      = NS'($urandom());
            in_payload  = {4{$urandom()}};
            in_valid    = ($urandom_range(0, 9) < 7);
            exe_valid   = ($urandom_range(0, 1) == 1);
            exe_is_load = ($urandom_range(0, 9) < 3);
            exe_addr    = AW'($urandom_range(0, 7));
            exe_data    = {$urandom(), $urandom()};
            wri_valid   = WB'($urandom());
            for (int j = 0; j < int'(WB); j++)
                set_wri(j, AW'($urandom_range(0, 7)), {$urandom(), $urandom()});
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        #2 chk("sb_drained", 256'(sb.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
Parametrised successor of the decode/operand-read stage. It sits between the micro-op queue head and the execute stage. It reads N_SRC register operands and resolves them through forwarding from one execute port and WB_N write-back layers, with address matching done internally. It adds a valid/ready handshake that holds its payload on a stall, refreshes held operands, detects load-use hazards and keeps saturating hazard/stall counters.

Parameters:
REG_W, 64, register width
REG_N, 16, number of GPRs
REG_ADDR_W, 4, register address width (2**REG_ADDR_W >= REG_N)
N_SRC, 3, operands per micro-op
WB_N, 2, write-back forwarding layers (index 0 = youngest)
PAYLOAD_W, 128, opaque pass-through bits (opcode, imm, bit mode, pc)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
flush  in  1  squash the stage
in_valid  in  1  queue head valid
in_ready  out  1  stage accepts the head this cycle
in_payload  in  PAYLOAD_W  pass-through fields
in_addr  in  N_SRC*REG_ADDR_W  operand addresses; operand i is at slice i
in_use  in  N_SRC  operand i is actually read
gpr_flat  in  REG_N*REG_W  architectural registers; register r is at slice r
exe_valid  in  1  execute stage holds a register-writing op
exe_is_load  in  1  that op is a load; its data is not available yet
exe_addr  in  REG_ADDR_W  execute destination
exe_data  in  REG_W  execute result
wri_valid  in  WB_N  write-back layer j writes a register
wri_addr  in  WB_N*REG_ADDR_W  write-back destinations
wri_data  in  WB_N*REG_W  write-back data
out_valid  out  1  decoded op valid
out_ready  in  1  execute accepts the op
out_payload  out  PAYLOAD_W  registered payload
out_addr  out  N_SRC*REG_ADDR_W  registered addresses
out_use  out  N_SRC  registered in_use
out_val  out  N_SRC*REG_W  resolved operand values
hazard_cnt  out  CNT_W  count of load-use stall cycles
stall_cnt  out  CNT_W  count of backpressure cycles

Behaviour:
- Reset (async, rstn=0): every registered output and both counters are 0; in_ready=0 while rstn=0.
- Operand select, combinational, for each operand i:
  - in_use[i]=0 -> value 0.
  - If exe_valid & ~exe_is_load & exe_addr==addr_i -> exe_data.
  - Else the lowest j with wri_valid[j] & wri_addr[j]==addr_i -> wri_data[j].
  - Else gpr[addr_i].
- load_use = in_valid & exe_valid & exe_is_load & OR over i of (in_use[i] & in_addr[i]==exe_addr).
- in_ready = rstn & ~flush & ~load_use & (~out_valid | out_ready). This path is combinational.
- accept = in_valid & in_ready. Latency from accept to out_valid is 1 cycle.
- Register update at each clock edge, highest priority first:
  1. flush -> out_valid=0; payload, addr, use and val are cleared to 0.
  2. accept -> load all fields; out_valid=1.
  3. out_valid & out_ready -> out_valid=0; the other fields hold.
  4. out_valid & ~out_ready (held) -> for each i with out_use[i], if some wri_valid[j] & wri_addr[j]==out_addr[i], replace out_val[i] with wri_data[j] (lowest j wins); other fields hold.
- A load-use hazard never drops a held op. It only blocks accept, so a bubble is emitted once the current op leaves.
- Counters saturate at all-ones and are cleared only by reset, never by flush.
  - hazard_cnt += 1 on each cycle with load_use.
  - stall_cnt += 1 on each cycle with out_valid & ~out_ready.
- Simultaneous events:
  - flush with in_valid -> nothing is accepted.
  - flush with a held op -> the op is dropped.
  - exe and wri both matching -> exe wins.
  - Two wri layers matching -> lower index wins.
- Reset asserted mid-stall -> immediate clear; the queue head is not consumed.

Test Plan:
- Reset then single op: gpr[3]=0x11, addr0=3, use=001, out_ready=1 -> next cycle out_valid=1, out_val[0]=0x11; in_ready=1 throughout.
- Forward priority: addr0=5; exe(5,0xAA,non-load), wri0(5,0xBB), wri1(5,0xCC) -> 0xAA. Drop exe -> 0xBB. Drop wri0 -> 0xCC.
- Load-use: exe_is_load=1, exe_addr=7, in_addr1=7, use[1]=1 -> in_ready=0 for 2 cycles, hazard_cnt=2, bubble (out_valid=0). Clear the load -> accept with forwarded value.
- Backpressure refresh: held op with addr0=4, out_ready=0 for 3 cycles, wri0(4,0x55) in cycle 2 -> out_val[0]=0x55 on release; stall_cnt=3; payload unchanged.
- Flush: flush together with in_valid and a held op -> out_valid=0 next cycle, nothing accepted, counters unchanged.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15.
